// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector with a runtime-loaded PAT_W-bit pattern.
// It supports overlapping or non-overlapping matching, a Moore or Mealy hit
// output, a saturating hit counter and an optional stop-after-N-hits limit.
module seq_detect_fsm #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int MEALY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             x_valid,
  input  logic             x_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic [CNT_W-1:0] max_hits,
  output logic             y_out,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    DETECT = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic             r_ovl;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  // The oldest history bit is shifted out before it is ever compared, so
  // only the PAT_W-1 most recent bits are stored.
  logic [PAT_W-2:0] r_hist, w_hist_nxt;
  logic [FW-1:0]    r_fill, w_fill_nxt;

  logic [PAT_W-1:0] w_cand;
  logic             w_active;
  logic             w_accept;
  logic             w_match;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_limit;
  logic             w_load;

  assign w_cand    = {r_hist, x_in};
  assign w_active  = (r_state == FILL) || (r_state == DETECT);
  assign w_accept  = x_valid && w_active;
  assign w_match   = w_accept && (r_fill >= FILL_LAST) && (w_cand == r_pat);
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
  assign w_limit   = (r_max != '0) && (w_cnt_inc == {1'b0, r_max});
  assign w_load    = start && !stop;

  // Next-state, history, fill and counter update; stop beats start beats data.
  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_cnt_nxt   = r_cnt;
    if (stop) begin
      w_state_nxt = IDLE;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else if (start) begin
      w_state_nxt = FILL;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_hist_nxt = w_cand[PAT_W-2:0];
      if (r_fill != FILL_FULL) w_fill_nxt = r_fill + 1'b1;
      if (r_fill >= FILL_LAST) w_state_nxt = DETECT;
      if (w_match) begin
        if (!(&r_cnt)) w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        if (!r_ovl) begin
          w_hist_nxt  = '0;
          w_fill_nxt  = '0;
          w_state_nxt = FILL;
        end
        if (w_limit) w_state_nxt = DONE;
      end
    end
  end

  // State, history, fill and hit counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Configuration captured on start (a simultaneous stop suppresses it).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pat <= '0;
      r_ovl <= 1'b0;
      r_max <= '0;
    end else if (w_load) begin
      r_pat <= pattern;
      r_ovl <= overlap;
      r_max <= max_hits;
    end
  end

  generate
    if (MEALY != 0) begin : g_mealy
      assign y_out = w_match;
    end else begin : g_moore
      logic r_y;
      logic w_y_nxt;
      // Matches discarded by start/stop must not produce a pulse.
      assign w_y_nxt = w_match && !start && !stop;
      // Registered one-cycle hit pulse.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_y <= 1'b0;
        else        r_y <= w_y_nxt;
      end
      assign y_out = r_y;
    end
  endgenerate

  assign hit_count = r_cnt;
  assign busy      = w_active;
  assign done      = (r_state == DONE);
  assign state_o   = r_state;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed self-checking bench for seq_detect_fsm: a Moore instance (CNT_W=8)
// and a Mealy instance (CNT_W=2) share one stimulus stream.
module tb_seq_detect_fsm;

  logic       clock;
  logic       reset;
  logic       start;
  logic       stop;
  logic       x_valid;
  logic       x_in;
  logic [3:0] pattern;
  logic       overlap;
  logic [7:0] max_hits;

  logic       y0, busy0, done0;
  logic [7:0] cnt0;
  logic [1:0] st0;
  logic       y1, busy1, done1;
  logic [1:0] cnt1;
  logic [1:0] st1;

  int n_cmp;
  int n_err;

  seq_detect_fsm #(.PAT_W(4), .CNT_W(8), .MEALY(0)) u_moore (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .x_valid(x_valid), .x_in(x_in), .pattern(pattern), .overlap(overlap),
    .max_hits(max_hits), .y_out(y0), .hit_count(cnt0), .busy(busy0),
    .done(done0), .state_o(st0)
  );

  seq_detect_fsm #(.PAT_W(4), .CNT_W(2), .MEALY(1)) u_mealy (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .x_valid(x_valid), .x_in(x_in), .pattern(pattern), .overlap(overlap),
    .max_hits(max_hits[1:0]), .y_out(y1), .hit_count(cnt1), .busy(busy1),
    .done(done1), .state_o(st1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pat, input logic ovl, input logic [7:0] mh);
    start    = 1'b1;
    pattern  = pat;
    overlap  = ovl;
    max_hits = mh;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    x_valid = 1'b1;
    x_in    = b;
    tick();
    x_valid = 1'b0;
  endtask

  // Back-to-back bits, MSB first; per-bit expectations for the Moore instance.
  // est/ecnt pack two bits per stimulus bit, first bit in the top pair.
  task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] ey, input logic [31:0] est,
                          input logic [31:0] ecnt);
    for (int k = 1; k <= n; k++) begin
      send(bits[n-k]);
      check($sformatf("%s.y%0d", tag, k), {31'd0, y0}, {31'd0, ey[n-k]});
      check($sformatf("%s.st%0d", tag, k), {30'd0, st0}, {30'd0, est[2*(n-k) +: 2]});
      check($sformatf("%s.cnt%0d", tag, k), {24'd0, cnt0}, {30'd0, ecnt[2*(n-k) +: 2]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    x_valid  = 1'b0;
    x_in     = 1'b0;
    pattern  = '0;
    overlap  = 1'b0;
    max_hits = '0;
    #1;
    check("rst.state", {30'd0, st0}, 32'd0);
    check("rst.y", {31'd0, y0}, 32'd0);
    check("rst.busy", {31'd0, busy0}, 32'd0);
    check("rst.done", {31'd0, done0}, 32'd0);
    check("rst.cnt", {24'd0, cnt0}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("idle.state", {30'd0, st0}, 32'd0);

    // Overlapping 1011: hits on bits 4 and 7.
    do_start(4'b1011, 1'b1, 8'd0);
    check("ovl.start_st", {30'd0, st0}, 32'd1);
    check("ovl.start_busy", {31'd0, busy0}, 32'd1);
    run_bits("ovl", 7, 16'b1011011, 16'b0001001,
             {18'd0, 14'b01_01_01_10_10_10_10},
             {18'd0, 14'b00_00_00_01_01_01_10});
    tick();
    check("ovl.y_drop", {31'd0, y0}, 32'd0);

    // Non-overlapping: hit on bit 4 restarts FILL; extra bits 0,1,1 give a
    // DETECT->FILL hit on bit 10.
    do_start(4'b1011, 1'b0, 8'd0);
    check("novl.start_cnt", {24'd0, cnt0}, 32'd0);
    run_bits("novl", 10, 16'b1011011011, 16'b0001000001,
             {12'd0, 20'b01_01_01_01_01_01_01_10_10_01},
             {12'd0, 20'b00_00_00_01_01_01_01_01_01_10});

    // Hit limit 3 on 1111: DONE from bit 6, later bits ignored.
    do_start(4'b1111, 1'b1, 8'd3);
    run_bits("lim", 10, 16'b1111111111, 16'b0001110000,
             {12'd0, 20'b01_01_01_10_10_11_11_11_11_11},
             {12'd0, 20'b00_00_00_01_10_11_11_11_11_11});
    check("lim.done", {31'd0, done0}, 32'd1);
    check("lim.busy", {31'd0, busy0}, 32'd0);

    // Mealy instance, 2-bit counter, bits separated by x_valid gaps.
    do_start(4'b1111, 1'b1, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      x_valid = 1'b1;
      x_in    = 1'b1;
      #1;
      check($sformatf("mealy.y%0d", k), {31'd0, y1}, (k >= 4) ? 32'd1 : 32'd0);
      tick();
      x_valid = 1'b0;
      check($sformatf("mealy.cnt%0d", k), {30'd0, cnt1},
            (k < 4) ? 32'd0 : ((k - 3 > 3) ? 32'd3 : 32'(k - 3)));
      #1;
      check($sformatf("mealy.gap_y%0d", k), {31'd0, y1}, 32'd0);
      tick();
    end

    // start and stop together in DETECT: stop wins, count held.
    do_start(4'b1011, 1'b1, 8'd0);
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    check("ss.pre_cnt", {24'd0, cnt0}, 32'd1);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss.state", {30'd0, st0}, 32'd0);
    check("ss.cnt", {24'd0, cnt0}, 32'd1);

    // start together with a completing bit: the match is discarded.
    do_start(4'b1011, 1'b1, 8'd0);
    send(1'b1); send(1'b0); send(1'b1);
    start    = 1'b1;
    x_valid  = 1'b1;
    x_in     = 1'b1;
    tick();
    start   = 1'b0;
    x_valid = 1'b0;
    check("sm.cnt", {24'd0, cnt0}, 32'd0);
    check("sm.state", {30'd0, st0}, 32'd1);
    check("sm.y", {31'd0, y0}, 32'd0);
    send(1'b1);
    check("sm.next_y", {31'd0, y0}, 32'd0);

    // Asynchronous reset mid-FILL with a would-be matching bit presented.
    do_start(4'b1011, 1'b1, 8'd0);
    send(1'b1); send(1'b0); send(1'b1);
    x_valid = 1'b1;
    x_in    = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("ar.state", {30'd0, st0}, 32'd0);
    check("ar.busy", {31'd0, busy0}, 32'd0);
    check("ar.done", {31'd0, done0}, 32'd0);
    check("ar.y", {31'd0, y0}, 32'd0);
    check("ar.cnt", {24'd0, cnt0}, 32'd0);
    tick();
    x_valid = 1'b0;
    reset   = 1'b1;
    tick();
    check("ar.post_y", {31'd0, y0}, 32'd0);
    check("ar.post_state", {30'd0, st0}, 32'd0);

    // Fresh start after reset: no stale hit, then a clean first hit.
    do_start(4'b1011, 1'b1, 8'd0);
    check("fs.cnt0", {24'd0, cnt0}, 32'd0);
    check("fs.y0", {31'd0, y0}, 32'd0);
    run_bits("fs", 4, 16'b1011, 16'b0001,
             {24'd0, 8'b01_01_01_10},
             {24'd0, 8'b00_00_00_01});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
